regfile_op_sequencer: RTL and testbench

Sequencer that drives the write port and both read ports of the 4-entry x 4-bit register file. It accepts one register-to-register instruction at a time over a valid/ready handshake, reads the two source operands, computes a 4-bit ALU result, and writes it back to the destination register. It is the initiator on the register-file interface and the only writer of the register file in the ALU datapath.

---
 rtl/regfile_op_sequencer.sv | 106 ++++++++++
 tb/tb_regfile_op_sequencer.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/regfile_op_sequencer.sv
// regfile_op_sequencer: four-phase read/exec/write sequencer driving a 2R1W register file with a small ALU
module regfile_op_sequencer #(
  parameter int DATA_W = 4,
  parameter int ADDR_W = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [2:0]        instr_op,
  input  logic [ADDR_W-1:0] instr_rd,
  input  logic [ADDR_W-1:0] instr_rs1,
  input  logic [ADDR_W-1:0] instr_rs2,
  input  logic [DATA_W-1:0] instr_imm,
  output logic [ADDR_W-1:0] read_addr1,
  output logic [ADDR_W-1:0] read_addr2,
  input  logic [DATA_W-1:0] read_data1,
  input  logic [DATA_W-1:0] read_data2,
  output logic [ADDR_W-1:0] write_addr,
  output logic [DATA_W-1:0] write_data,
  output logic              reg_write,
  output logic [DATA_W-1:0] result,
  output logic              carry,
  output logic              zero,
  output logic              done
);
  typedef enum logic [1:0] {IDLE, READ, EXEC, WRITE} state_t;
  state_t state_q, state_d;
  logic [2:0]        op_q;
  logic [ADDR_W-1:0] rd_q, rs1_q, rs2_q;
  logic [DATA_W-1:0] imm_q, a_q, b_q, res_q, res_d;
  logic              c_q, c_d, z_q;
  logic [DATA_W:0]   sum;
  logic              nop, accept;
  assign nop    = op_q[2] & |op_q[1:0];
  assign accept = instr_valid & instr_ready;
  assign sum    = {1'b0, a_q} + {1'b0, b_q};
  always_comb begin
    state_d     = state_q;
    instr_ready = (state_q == IDLE) & ~rst;
    read_addr1  = (state_q == READ) ? rs1_q : '0;
    read_addr2  = (state_q == READ) ? rs2_q : '0;
    write_addr  = (state_q == WRITE) ? rd_q : '0;
    write_data  = (state_q == WRITE) ? res_q : '0;
    reg_write   = (state_q == WRITE) & ~nop;
    done        = (state_q == WRITE);
    result      = res_q;
    carry       = c_q;
    zero        = z_q;
    case (state_q)
      IDLE:    state_d = accept ? READ : IDLE;
      READ:    state_d = EXEC;
      EXEC:    state_d = WRITE;
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    res_d = res_q;
    c_d   = 1'b0;
    case (op_q)
      3'd0: {c_d, res_d} = sum;
      3'd1: begin
        res_d = a_q - b_q;
        c_d   = a_q < b_q;
      end
      3'd2:    res_d = a_q & b_q;
      3'd3:    res_d = a_q | b_q;
      3'd4:    res_d = imm_q;
      default: c_d = c_q;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      op_q    <= '0;
      rd_q    <= '0;
      rs1_q   <= '0;
      rs2_q   <= '0;
      imm_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      c_q     <= 1'b0;
      z_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        op_q  <= instr_op;
        rd_q  <= instr_rd;
        rs1_q <= instr_rs1;
        rs2_q <= instr_rs2;
        imm_q <= instr_imm;
      end
      if (state_q == READ) begin
        a_q <= read_data1;
        b_q <= read_data2;
      end
      // NOP leaves the flags and result exactly as the previous instruction left them
      if (state_q == EXEC && !nop) begin
        res_q <= res_d;
        c_q   <= c_d;
        z_q   <= (res_d == '0);
      end
    end
  end
endmodule

// File: tb/tb_regfile_op_sequencer.sv
// tb_regfile_op_sequencer: bench with external register file, timeline model and randomized plus directed stimulus
module tb_regfile_op_sequencer;
  logic clk = 0, rst = 1, clr = 1;
  logic instr_valid = 0, instr_ready;
  logic [2:0] instr_op = 0;
  logic [1:0] instr_rd = 0, instr_rs1 = 0, instr_rs2 = 0;
  logic [3:0] instr_imm = 0;
  logic [1:0] read_addr1, read_addr2, write_addr;
  logic [3:0] read_data1, read_data2, write_data, result;
  logic reg_write, carry, zero, done;
  int total = 0, bad = 0, cyc = 0;
  logic [3:0] rf [4];
  logic [3:0] mrf [4];
  always #5 clk = ~clk;
  regfile_op_sequencer #(.DATA_W(4), .ADDR_W(2)) dut (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_op(instr_op), .instr_rd(instr_rd), .instr_rs1(instr_rs1), .instr_rs2(instr_rs2),
    .instr_imm(instr_imm), .read_addr1(read_addr1), .read_addr2(read_addr2),
    .read_data1(read_data1), .read_data2(read_data2), .write_addr(write_addr),
    .write_data(write_data), .reg_write(reg_write), .result(result), .carry(carry),
    .zero(zero), .done(done));
  assign read_data1 = rf[read_addr1];
  assign read_data2 = rf[read_addr2];
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (clr) for (int i = 0; i < 4; i++) rf[i] <= 0;
    else if (reg_write) rf[write_addr] <= write_data;
  end
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", n, a, e, $time);
    end
  endtask
  function automatic logic [4:0] alu(input logic [2:0] op, input int a, input int b, input logic [3:0] imm);
    case (op)
      3'd0: return 5'(a + b);
      3'd1: return {(a < b) ? 1'b1 : 1'b0, 4'((a - b + 16) % 16)};
      3'd2: return {1'b0, 4'(a & b)};
      3'd3: return {1'b0, 4'(a | b)};
      3'd4: return {1'b0, imm};
      default: return 5'd0;
    endcase
  endfunction
  // ph counts cycles since the accepting edge; 0 means waiting for an instruction
  int ph = 0;
  logic [2:0] mop;
  logic [1:0] mrd, mrs1, mrs2;
  logic [4:0] pend;
  logic [3:0] sres;
  logic sc, sz, mnop;
  assign mnop = mop >= 3'd5;
  always @(posedge clk) begin
    if (clr) for (int i = 0; i < 4; i++) mrf[i] <= 0;
    if (rst) begin
      ph <= 0; sres <= 0; sc <= 0; sz <= 0; mop <= 0;
    end else if (ph == 0) begin
      if (instr_valid) begin
        ph <= 1; mop <= instr_op; mrd <= instr_rd; mrs1 <= instr_rs1; mrs2 <= instr_rs2;
        pend <= alu(instr_op, int'(mrf[instr_rs1]), int'(mrf[instr_rs2]), instr_imm);
      end
    end else if (ph == 1) ph <= 2;
    else if (ph == 2) begin
      ph <= 3;
      if (!mnop) begin sres <= pend[3:0]; sc <= pend[4]; sz <= pend[3:0] == 0; end
    end else begin
      ph <= 0;
      if (!mnop) mrf[mrd] <= sres;
    end
  end
  always @(negedge clk) begin
    if (rst)
      chk("reset_outs", {instr_ready, reg_write, done, result, carry, zero, read_addr1, read_addr2, write_addr, write_data}, 0);
    else begin
      chk("ready", instr_ready, ph == 0);
      chk("raddr", {read_addr1, read_addr2}, ph == 1 ? {mrs1, mrs2} : 4'd0);
      chk("wport", {reg_write, done, write_addr, write_data}, ph == 3 ? {~mnop, 1'b1, mrd, sres} : 8'd0);
      chk("flags", {result, carry, zero}, {sres, sc, sz});
    end
    if (!clr) chk("regfile", {rf[0], rf[1], rf[2], rf[3]}, {mrf[0], mrf[1], mrf[2], mrf[3]});
  end
  task automatic issue(input logic [2:0] op, input logic [1:0] rd, rs1, rs2, input logic [3:0] imm, input bit hold, output int acc);
    bit r = 0;
    instr_valid = 1; instr_op = op; instr_rd = rd; instr_rs1 = rs1; instr_rs2 = rs2; instr_imm = imm;
    for (int k = 0; k < 20 && !r; k++) begin
      @(negedge clk); r = instr_ready;
      @(posedge clk);
    end
    #1;
    if (!r) chk("accept_timeout", 0, 1);
    acc = cyc;
    if (!hold) instr_valid = 0;
  endtask
  task automatic do_op(input logic [2:0] op, input logic [1:0] rd, rs1, rs2, input logic [3:0] imm,
                       input logic [3:0] ewd, input logic ec, ez);
    int acc;
    issue(op, rd, rs1, rs2, imm, 0, acc);
    @(negedge clk); @(negedge clk);
    chk("done_early", done, 0);
    @(negedge clk);
    chk("lit_done", {done, reg_write, write_addr}, {1'b1, 1'b1, rd});
    chk("lit_wdata", write_data, ewd);
    chk("lit_cz", {carry, zero}, {ec, ez});
    @(posedge clk); #1;
    chk("lit_rf", rf[rd], ewd);
  endtask
  task automatic rst_in(input int s);
    int acc;
    logic [3:0] r2;
    r2 = mrf[2];
    if (s > 0) begin
      issue(3'd0, 2'd2, 2'd1, 2'd1, 4'd0, 0, acc);
      repeat (s) @(negedge clk);
    end else @(negedge clk);
    #2 rst = 1;
    #1 chk("lit_rst_zero", {instr_ready, reg_write, done, result, carry, zero}, 0);
    @(posedge clk); #1 rst = 0;
    @(negedge clk);
    chk("lit_ready_after_rst", instr_ready, 1);
    chk("lit_r2_kept", rf[2], r2);
    @(posedge clk); #1;
  endtask
  initial begin
    int a0, a1, a2;
    repeat (2) @(posedge clk);
    #1 rst = 0; clr = 0;
    @(negedge clk);
    chk("lit_init_ready", instr_ready, 1);
    @(posedge clk); #1;
    do_op(3'd4, 2'd1, 2'd0, 2'd0, 4'd5, 4'd5, 0, 0);
    do_op(3'd4, 2'd2, 2'd0, 2'd0, 4'd3, 4'd3, 0, 0);
    do_op(3'd0, 2'd3, 2'd1, 2'd2, 4'd0, 4'd8, 0, 0);
    do_op(3'd4, 2'd1, 2'd0, 2'd0, 4'hF, 4'hF, 0, 0);
    do_op(3'd4, 2'd2, 2'd0, 2'd0, 4'd1, 4'd1, 0, 0);
    do_op(3'd0, 2'd0, 2'd1, 2'd2, 4'd0, 4'd0, 1, 1);
    do_op(3'd4, 2'd1, 2'd0, 2'd0, 4'd3, 4'd3, 0, 0);
    do_op(3'd4, 2'd2, 2'd0, 2'd0, 4'd5, 4'd5, 0, 0);
    do_op(3'd1, 2'd3, 2'd1, 2'd2, 4'd0, 4'hE, 1, 0);
    do_op(3'd1, 2'd3, 2'd2, 2'd1, 4'd0, 4'h2, 0, 0);
    do_op(3'd2, 2'd3, 2'd1, 2'd2, 4'd0, 4'h1, 0, 0);
    do_op(3'd3, 2'd3, 2'd1, 2'd2, 4'd0, 4'h7, 0, 0);
    issue(3'd5, 2'd3, 2'd1, 2'd2, 4'd9, 0, a0);
    repeat (3) @(negedge clk);
    chk("lit_nop", {done, reg_write, result, carry, zero}, {1'b1, 1'b0, 4'h7, 1'b0, 1'b0});
    @(posedge clk); #1;
    chk("lit_nop_rf", rf[3], 4'h7);
    issue(3'd4, 2'd1, 2'd0, 2'd0, 4'd2, 1, a0);
    issue(3'd0, 2'd1, 2'd1, 2'd1, 4'd0, 1, a1);
    issue(3'd0, 2'd1, 2'd1, 2'd1, 4'd0, 0, a2);
    repeat (4) @(posedge clk); #1;
    chk("lit_b2b_gap", {a1 - a0, a2 - a1}, {32'd4, 32'd4});
    chk("lit_b2b_r1", rf[1], 4'd8);
    for (int s = 0; s < 4; s++) rst_in(s);
    for (int i = 0; i < 800; i++) begin
      @(posedge clk); #1;
      rst = !rst && $urandom_range(0, 59) == 0;
      instr_valid = $urandom_range(0, 2) != 0;
      instr_op = 3'($urandom_range(0, 7));
      instr_rd = 2'($urandom);
      instr_rs1 = 2'($urandom);
      instr_rs2 = 2'($urandom);
      instr_imm = 4'($urandom);
    end
    @(posedge clk); #1 rst = 0; instr_valid = 0;
    repeat (6) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
